// File: rtl/uart_edge_pkg.sv
// ============================================================================
// Module  : uart_edge_pkg
// Purpose : Shared edge-mode type, default parameters and mode decode helper
//           for the uart_edge_filter block.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package uart_edge_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'b00,
        RISE = 2'b01,
        FALL = 2'b10,
        BOTH = 2'b11
    } edge_mode_e;

    localparam int DEF_BUS_WIDTH   = 32;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_FILT_WIDTH  = 8;

    // True when the channel mode qualifies an edge in the given direction.
    function automatic logic edge_enabled(input edge_mode_e mode, input logic rising);
        if (rising) begin
            return (mode == RISE) || (mode == BOTH);
        end
        return (mode == FALL) || (mode == BOTH);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_glitch_filter.sv
// ============================================================================
// Module  : uart_glitch_filter
// Purpose : One channel: input synchronizer, glitch counter and debounced level.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module uart_glitch_filter
    import uart_edge_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILT_WIDTH  = DEF_FILT_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_data,
    input  logic [FILT_WIDTH-1:0] i_filt_len,
    output logic                  o_filtered,
    output logic                  o_toggle
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [FILT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                   filt_q, filt_d;
    logic                   sample_w;

    assign sample_w = sync_q[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_data};
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    // A count already past a freshly lowered threshold commits immediately.
    always_comb begin
        cnt_d    = '0;
        filt_d   = filt_q;
        o_toggle = 1'b0;
        if (sample_w != filt_q) begin
            if (cnt_q >= i_filt_len) begin
                filt_d   = sample_w;
                o_toggle = 1'b1;
            end else begin
                cnt_d = cnt_q + FILT_WIDTH'(1);
            end
        end
    end

    assign o_filtered = filt_q;

endmodule

`default_nettype wire

// File: rtl/uart_edge_filter.sv
// ============================================================================
// Module  : uart_edge_filter
// Purpose : Multi-channel synchronizer / glitch filter with edge pulses,
//           sticky flags and interrupt. Define UART_EDGE_FILTER_OVERRUN_EN
//           to add the sticky o_overrun port.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module uart_edge_filter
    import uart_edge_pkg::*;
#(
    parameter int BUS_WIDTH   = DEF_BUS_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILT_WIDTH  = DEF_FILT_WIDTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [BUS_WIDTH-1:0]   i_data,
    input  logic [2*BUS_WIDTH-1:0] i_mode,
    input  logic [FILT_WIDTH-1:0]  i_filt_len,
    input  logic [BUS_WIDTH-1:0]   i_clear,
    output logic [BUS_WIDTH-1:0]   o_filtered,
    output logic [BUS_WIDTH-1:0]   o_edge_pulse,
    output logic [BUS_WIDTH-1:0]   o_flags,
    output logic                   o_irq
`ifdef UART_EDGE_FILTER_OVERRUN_EN
    ,
    output logic [BUS_WIDTH-1:0]   o_overrun
`endif
);

    logic [BUS_WIDTH-1:0] toggle_w;
    logic [BUS_WIDTH-1:0] pulse_d, pulse_q;
    logic [BUS_WIDTH-1:0] flags_d, flags_q;

    for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_chan
        edge_mode_e mode_w;

        assign mode_w = edge_mode_e'(i_mode[2*i +: 2]);

        uart_glitch_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_WIDTH  (FILT_WIDTH)
        ) u_filt (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_data     (i_data[i]),
            .i_filt_len (i_filt_len),
            .o_filtered (o_filtered[i]),
            .o_toggle   (toggle_w[i])
        );

        // Pulse lands with the new filtered level; a low level now means a rise.
        assign pulse_d[i] = toggle_w[i] & edge_enabled(mode_w, ~o_filtered[i]);
    end

    // Set wins over clear so an edge coinciding with a clear is never lost.
    assign flags_d = (flags_q & ~i_clear) | pulse_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pulse_q <= '0;
            flags_q <= '0;
        end else begin
            pulse_q <= pulse_d;
            flags_q <= flags_d;
        end
    end

    assign o_edge_pulse = pulse_q;
    assign o_flags      = flags_q;
    assign o_irq        = |flags_q;

`ifdef UART_EDGE_FILTER_OVERRUN_EN
    logic [BUS_WIDTH-1:0] overrun_d, overrun_q;

    assign overrun_d = (overrun_q & ~i_clear) | (pulse_q & flags_q & ~i_clear);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            overrun_q <= '0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign o_overrun = overrun_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_edge_filter.sv
// ============================================================================
// Module  : tb_uart_edge_filter
// Purpose : Directed bench with a timestamp-based reference model checked
//           every cycle, plus hand-computed latency/flag expectations.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_edge_filter;

    localparam int BW = 32;
    localparam int SS = 2;
    localparam int FW = 8;

    logic            clk = 1'b0;
    logic            i_rst;
    logic [BW-1:0]   i_data;
    logic [2*BW-1:0] i_mode;
    logic [FW-1:0]   i_filt_len;
    logic [BW-1:0]   i_clear;
    logic [BW-1:0]   o_filtered, o_edge_pulse, o_flags;
    logic            o_irq;
`ifdef UART_EDGE_FILTER_OVERRUN_EN
    logic [BW-1:0]   o_overrun;
`endif

    uart_edge_filter #(
        .BUS_WIDTH   (BW),
        .SYNC_STAGES (SS),
        .FILT_WIDTH  (FW)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_data       (i_data),
        .i_mode       (i_mode),
        .i_filt_len   (i_filt_len),
        .i_clear      (i_clear),
        .o_filtered   (o_filtered),
        .o_edge_pulse (o_edge_pulse),
        .o_flags      (o_flags),
        .o_irq        (o_irq)
`ifdef UART_EDGE_FILTER_OVERRUN_EN
        ,
        .o_overrun    (o_overrun)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    endtask

    // Reference model: the filter commits once the sample has disagreed with
    // the level for L+1 consecutive edges, timed from the edge the streak began.
    int            edge_n   = 0;
    int            rst_edge = 0;
    logic [BW-1:0] dhist [int];
    logic [BW-1:0] m_f = '0, m_pulse = '0, m_flags = '0, m_ovr = '0;
    logic [BW-1:0] m_s, m_np;
    int            since [BW];

    initial begin
        foreach (since[i]) since[i] = -1;
        forever begin
            @(posedge clk);
            edge_n++;
            dhist[edge_n] = i_data;
            if (i_rst) begin
                m_f = '0; m_pulse = '0; m_flags = '0; m_ovr = '0;
                rst_edge = edge_n;
                foreach (since[i]) since[i] = -1;
            end else begin
                m_s  = (edge_n - SS > rst_edge) ? dhist[edge_n - SS] : '0;
                m_np = '0;
                for (int i = 0; i < BW; i++) begin
                    if (m_s[i] != m_f[i]) begin
                        if (since[i] < 0) since[i] = edge_n;
                        if (edge_n - since[i] >= int'(i_filt_len)) begin
                            m_np[i]  = m_s[i] ? i_mode[2*i] : i_mode[2*i+1];
                            m_f[i]   = m_s[i];
                            since[i] = -1;
                        end
                    end else begin
                        since[i] = -1;
                    end
                end
                m_ovr   = (m_ovr & ~i_clear) | (m_pulse & m_flags & ~i_clear);
                m_flags = (m_flags & ~i_clear) | m_pulse;
                m_pulse = m_np;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("model_filtered", 64'(o_filtered), 64'(m_f));
                chk("model_pulse", 64'(o_edge_pulse), 64'(m_pulse));
                chk("model_flags", 64'(o_flags), 64'(m_flags));
                chk("model_irq", 64'(o_irq), 64'(|m_flags));
`ifdef UART_EDGE_FILTER_OVERRUN_EN
                chk("model_overrun", 64'(o_overrun), 64'(m_ovr));
`endif
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        i_rst      = 1'b1;
        i_data     = '0;
        i_clear    = '0;
        i_filt_len = 8'd3;
        i_mode     = '0;
        i_mode[1:0]   = 2'b01;   // ch0 rise
        i_mode[3:2]   = 2'b11;   // ch1 both
        i_mode[5:4]   = 2'b10;   // ch2 fall
        i_mode[7:6]   = 2'b00;   // ch3 off
        i_mode[9:8]   = 2'b11;
        i_mode[11:10] = 2'b11;
        i_mode[13:12] = 2'b11;
        i_mode[15:14] = 2'b11;
        i_mode[17:16] = 2'b11;
        cycles(1);
        chk_en = 1'b1;
        cycles(2);
        chk("reset_filtered", 64'(o_filtered), 64'd0);
        chk("reset_flags", 64'(o_flags), 64'd0);
        chk("reset_irq", 64'(o_irq), 64'd0);
        i_rst = 1'b0;
        cycles(3);

        // ch0 rise, L=3: level follows 6 edges later
        i_data[0] = 1'b1;
        cycles(5);
        chk("lat_ch0_before", 64'(o_filtered[0]), 64'd0);
        cycles(1);
        chk("lat_ch0_level", 64'(o_filtered[0]), 64'd1);
        chk("lat_ch0_pulse", 64'(o_edge_pulse[0]), 64'd1);
        cycles(1);
        chk("lat_ch0_pulse_end", 64'(o_edge_pulse[0]), 64'd0);
        chk("lat_ch0_flag", 64'(o_flags[0]), 64'd1);
        chk("lat_ch0_irq", 64'(o_irq), 64'd1);
        i_data[0] = 1'b0;      // fall: rise-only mode, no pulse
        cycles(8);

        // ch5: 3-sample glitch rejected, 4-sample pulse passes
        i_data[5] = 1'b1;
        cycles(3);
        i_data[5] = 1'b0;
        cycles(8);
        chk("glitch3_level", 64'(o_filtered[5]), 64'd0);
        chk("glitch3_flag", 64'(o_flags[5]), 64'd0);
        i_data[5] = 1'b1;
        cycles(4);
        i_data[5] = 1'b0;
        cycles(10);
        chk("pulse4_flag", 64'(o_flags[5]), 64'd1);

        // ch2 fall-only, ch3 off
        i_data[2] = 1'b1;
        i_data[3] = 1'b1;
        cycles(8);
        chk("ch2_rise_level", 64'(o_filtered[2]), 64'd1);
        chk("ch2_rise_noflag", 64'(o_flags[2]), 64'd0);
        chk("ch3_off_level", 64'(o_filtered[3]), 64'd1);
        i_data[2] = 1'b0;
        cycles(8);
        chk("ch2_fall_flag", 64'(o_flags[2]), 64'd1);
        chk("ch3_off_noflag", 64'(o_flags[3]), 64'd0);

        // ch8: threshold lowered mid-count commits on the next edge
        i_filt_len = 8'd8;
        i_data[8]  = 1'b1;
        cycles(6);
        chk("ch8_midcount_level", 64'(o_filtered[8]), 64'd0);
        i_filt_len = 8'd1;
        cycles(1);
        chk("ch8_short_level", 64'(o_filtered[8]), 64'd1);
        i_filt_len = 8'd3;
        cycles(3);

        // ch1: clear coinciding with the setting edge loses nothing
        i_data[1] = 1'b1;
        cycles(6);
        chk("ch1_pulse", 64'(o_edge_pulse[1]), 64'd1);
        i_clear[1] = 1'b1;
        cycles(1);
        i_clear[1] = 1'b0;
        chk("ch1_set_wins", 64'(o_flags[1]), 64'd1);
        cycles(2);
        i_clear = '1;
        cycles(1);
        i_clear = '0;
        chk("clear_all_flags", 64'(o_flags), 64'd0);
        chk("clear_all_irq", 64'(o_irq), 64'd0);

        // ch7: second edge while flagged
        i_data[7] = 1'b1;
        cycles(10);
        i_data[7] = 1'b0;
        cycles(10);
        chk("ch7_flag", 64'(o_flags[7]), 64'd1);
`ifdef UART_EDGE_FILTER_OVERRUN_EN
        chk("ch7_overrun", 64'(o_overrun[7]), 64'd1);
`endif
        i_clear[7] = 1'b1;
        cycles(1);
        i_clear[7] = 1'b0;
        chk("ch7_flag_clr", 64'(o_flags[7]), 64'd0);
`ifdef UART_EDGE_FILTER_OVERRUN_EN
        chk("ch7_overrun_clr", 64'(o_overrun[7]), 64'd0);
`endif
        cycles(2);

        // ch4: reset two edges into a 5-edge count; ch1 stays high through it
        i_filt_len = 8'd5;
        i_data[4]  = 1'b1;
        cycles(4);
        i_rst     = 1'b1;
        i_data[4] = 1'b0;
        cycles(1);
        chk("midreset_filtered", 64'(o_filtered), 64'd0);
        chk("midreset_pulse", 64'(o_edge_pulse), 64'd0);
        chk("midreset_flags", 64'(o_flags), 64'd0);
        chk("midreset_irq", 64'(o_irq), 64'd0);
        i_rst = 1'b0;
        cycles(7);
        chk("held_ch1_before", 64'(o_filtered[1]), 64'd0);
        cycles(1);
        chk("held_ch1_level", 64'(o_filtered[1]), 64'd1);
        chk("held_ch1_pulse", 64'(o_edge_pulse[1]), 64'd1);
        cycles(12);
        chk("midreset_ch4_level", 64'(o_filtered[4]), 64'd0);
        chk("midreset_ch4_flag", 64'(o_flags[4]), 64'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_edge_filter.md
UART_EDGE_FILTER -- requirements
Module: uart_edge_filter

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32: number of independent input channels.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, legal range 2..4: synchronizer flops per channel.
REQ-003 SHALL have parameter FILT_WIDTH, default 8: width of the glitch-filter counter and threshold.
REQ-004 SHALL have port i_clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port i_data  input  BUS_WIDTH  asynchronous channel inputs.
REQ-007 SHALL have port i_mode  input  2*BUS_WIDTH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both.
REQ-008 SHALL have port i_filt_len  input  FILT_WIDTH  glitch threshold L, shared by all channels.
REQ-009 SHALL have port i_clear  input  BUS_WIDTH  write-1-to-clear strobe for o_flags.
REQ-010 SHALL have port o_filtered  output  BUS_WIDTH  debounced channel level.
REQ-011 SHALL have port o_edge_pulse  output  BUS_WIDTH  one-cycle pulse per qualified edge.
REQ-012 SHALL have port o_flags  output  BUS_WIDTH  sticky event flags.
REQ-013 SHALL have port o_irq  output  1  OR of all o_flags bits.

Function
REQ-014 SHALL pass each i_data bit through SYNC_STAGES flops; the last stage is the sample s[i].
REQ-015 SHALL keep a per-channel counter cnt[i] of FILT_WIDTH bits, with this per-cycle update:
- s!=f and cnt==L: f<=s, cnt<=0.
- s!=f and cnt!=L: cnt<=cnt+1.
- s==f: cnt<=0.
REQ-016 SHALL make latency from an i_data change to the o_filtered change exactly SYNC_STAGES+L+1 cycles; with L=0 the filter is transparent and latency is SYNC_STAGES+1.
REQ-017 SHALL reject any input pulse held L or fewer samples at s; o_filtered and o_edge_pulse stay unchanged.
REQ-018 SHALL sample i_filt_len every cycle; a change while cnt is mid-count applies immediately, and cnt>L with s!=f is treated as cnt==L.
REQ-019 SHALL assert o_edge_pulse[i] registered for exactly one cycle, in the first cycle o_filtered[i] shows its new value, only when the mode enables that edge direction.
REQ-020 SHALL leave filtering and o_filtered running in mode 00 while suppressing pulses and flags.
REQ-021 SHALL set o_flags[i] in the cycle after o_edge_pulse[i]; the flag then holds until cleared.
REQ-022 SHALL clear o_flags[i] one cycle after i_clear[i]=1; a simultaneous set and clear resolves to set, so no event is lost.
REQ-023 SHALL drive o_irq combinationally as |o_flags.

Reset
REQ-024 SHALL, with i_rst high at a clock edge, zero the sync chains, cnt, o_filtered, o_edge_pulse, o_flags and o_overrun (when present); o_irq follows as 0.
REQ-025 SHALL treat an input held high through reset as a rising edge after the REQ-016 latency.
REQ-026 SHALL abandon any count in progress when reset is asserted mid-filter, with no pulse generated.

Configuration
REQ-027 SHALL, with macro UART_EDGE_FILTER_OVERRUN_EN defined, add port o_overrun (output, BUS_WIDTH), which is sticky:
- Set when a qualified edge occurs while o_flags[i] is already 1 and not being cleared that cycle.
- Cleared by i_clear[i] with the same priority rule as REQ-022.
REQ-028 SHALL, without that macro, have no o_overrun port and no associated logic.

Structure
REQ-029 SHALL take from shared package uart_edge_pkg:
- Typedef edge_mode_e: OFF, RISE, FALL, BOTH.
- Default parameter constants.
REQ-030 SHALL instantiate per channel one sub-module, uart_glitch_filter, containing the sync chain, counter and filtered level; pulse, flag and mode logic stay in the top module.

Verification
REQ-031 SHALL cover: SYNC_STAGES=2, L=3, mode 01, i_data[0] 0->1 held -> o_filtered[0] rises 6 cycles later, one o_edge_pulse[0], o_flags[0]=1 next cycle, o_irq=1.
REQ-032 SHALL cover: L=3, a 3-cycle high glitch on i_data[5] -> no change on o_filtered, o_edge_pulse or o_flags; a 4-cycle pulse -> filtered pulse passes.
REQ-033 SHALL cover: mode 10 on channel 2, full rise then fall -> a pulse on the fall only; mode 00 -> o_filtered toggles with no pulse or flag.
REQ-034 SHALL cover: i_clear[1]=1 in the same cycle an edge sets flag 1 -> o_flags[1] stays 1; a clear on a later cycle -> 0, o_irq=0.
REQ-035 SHALL cover: i_rst asserted 2 cycles into a 5-cycle count -> all outputs 0, and no pulse after reset release while the input stays low.
REQ-036 SHALL cover: with UART_EDGE_FILTER_OVERRUN_EN, two qualified edges on channel 7 without a clear -> o_overrun[7]=1, then i_clear[7] -> both o_overrun[7] and o_flags[7] return to 0.
